seq_word_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly upstream of the bit-serial sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock onto `ser_out`, which connects straight to the detector's `inp`. Between words and while idle it holds the line at a configurable idle level. With the default idle level of 1, idle time resets a "001"-style detector instead of feeding it spurious zeros.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_word_serializer.sv | 120 ++++++++++++
 tb/tb_seq_word_serializer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types for the bit-serial sequence family: FSM state encoding and
// the default line level used while no word bit is on the wire.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } seq_state_e;

    localparam logic SEQ_IDLE_BIT = 1'b1;

endpackage

// File: rtl/seq_word_serializer.sv
// Parallel-in/serial-out word serializer feeding the bit-serial detectors:
// one word bit per clock on ser_out, idle level between words.
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_BIT   = SEQ_IDLE_BIT,
    parameter int   GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       GAP_INIT = 8'(GAP_CYCLES);

    seq_state_e       state_q, state_d, state_dec;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_adv;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]       gapcnt_q, gapcnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             accept, cur_bit, last_bit;

    // The unused encoding 2'b11 behaves exactly like IDLE.
    always_comb begin
        case (state_q)
            SHIFT:   state_dec = SHIFT;
            GAP:     state_dec = GAP;
            default: state_dec = IDLE;
        endcase
    end

    assign cur_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    assign last_bit  = (bitcnt_q == '0);

    // Ready depends on state/counter only; with no gap the last-bit cycle
    // doubles as the acceptance slot so consecutive words run without a bubble.
    assign din_ready = (state_dec == IDLE) ||
                       ((state_dec == SHIFT) && last_bit && (GAP_CYCLES == 0));
    assign accept    = din_valid && din_ready;
    assign busy      = (state_dec != IDLE);
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;

    always_comb begin
        state_d     = state_dec;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        gapcnt_d    = gapcnt_q;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
        case (state_dec)
            SHIFT: begin
                ser_out_d   = cur_bit;
                ser_valid_d = 1'b1;
                shreg_d     = shreg_adv;
                if (last_bit) begin
                    word_done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        gapcnt_d = GAP_INIT;
                    end else if (accept) begin
                        shreg_d  = din;
                        bitcnt_d = CNT_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bitcnt_d = bitcnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (gapcnt_q != 8'd0) gapcnt_d = gapcnt_q - 8'd1;
                if (gapcnt_q <= 8'd1) state_d = IDLE;
            end
            default: begin
                if (accept) begin
                    shreg_d  = din;
                    bitcnt_d = CNT_LAST;
                    state_d  = SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            gapcnt_q    <= gapcnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: tb/tb_seq_word_serializer.sv
// Bench for seq_word_serializer: four parameterisations share one stimulus
// stream; directed scenarios plus randomized traffic against a timing model.
module tb_seq_word_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic [3:0] so, sv, bz, dn, rd;
    int         errs = 0;
    int         checks = 0;

    // Configuration table: width, msb-first, idle level, gap cycles.
    int cW [4] = '{8, 8, 8, 5};
    bit cM [4] = '{1, 0, 1, 0};
    bit cI [4] = '{1, 1, 1, 0};
    int cG [4] = '{0, 0, 3, 1};

    always #5 clk = ~clk;

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rd[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .busy(bz[0]), .word_done(dn[0]));
    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rd[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .busy(bz[1]), .word_done(dn[1]));
    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP_CYCLES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rd[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .busy(bz[2]), .word_done(dn[2]));
    seq_word_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP_CYCLES(1)) u3 (
        .clk(clk), .rst_n(rst_n), .din(din[4:0]), .din_valid(din_valid), .din_ready(rd[3]),
        .ser_out(so[3]), .ser_valid(sv[3]), .busy(bz[3]), .word_done(dn[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        din_valid = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            checks++; if (so[c] !== cI[c]) begin errs++; $display("FAIL rst_ser_out cfg%0d got=%b exp=%b", c, so[c], cI[c]); end
            checks++; if (sv[c] !== 1'b0) begin errs++; $display("FAIL rst_ser_valid cfg%0d got=%b exp=0", c, sv[c]); end
            checks++; if (rd[c] !== 1'b1) begin errs++; $display("FAIL rst_din_ready cfg%0d got=%b exp=1", c, rd[c]); end
            checks++; if (bz[c] !== 1'b0) begin errs++; $display("FAIL rst_busy cfg%0d got=%b exp=0", c, bz[c]); end
            checks++; if (dn[c] !== 1'b0) begin errs++; $display("FAIL rst_word_done cfg%0d got=%b exp=0", c, dn[c]); end
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if ({so[0], sv[0], rd[0], bz[0], dn[0]} !== 5'b10100) begin
                errs++; $display("FAIL idle_after_rst cycle%0d got=%b exp=10100", k, {so[0], sv[0], rd[0], bz[0], dn[0]});
            end
            tick();
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] pat;
        logic eb, ev;
        pat = 8'b0010_0001;
        settle();
        din = pat;
        din_valid = 1'b1;
        @(negedge clk);
        checks++; if (rd[0] !== 1'b1) begin errs++; $display("FAIL msb_ready_idle got=%b exp=1", rd[0]); end
        tick();
        din_valid = 1'b0;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            ev = (i >= 1 && i <= 8);
            eb = ev ? pat[8-i] : 1'b1;
            checks++; if (so[0] !== eb) begin errs++; $display("FAIL msb_bit i=%0d got=%b exp=%b", i, so[0], eb); end
            checks++; if (sv[0] !== ev) begin errs++; $display("FAIL msb_valid i=%0d got=%b exp=%b", i, sv[0], ev); end
            checks++; if (dn[0] !== (i == 8)) begin errs++; $display("FAIL msb_done i=%0d got=%b exp=%b", i, dn[0], (i == 8)); end
            checks++; if (bz[0] !== (i <= 7)) begin errs++; $display("FAIL msb_busy i=%0d got=%b exp=%b", i, bz[0], (i <= 7)); end
            tick();
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] pat;
        logic eb, ev;
        pat = 8'hA5;
        settle();
        din = pat;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din = 8'h00;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            ev = (i >= 1 && i <= 8);
            eb = ev ? pat[i-1] : 1'b1;
            checks++; if (so[1] !== eb) begin errs++; $display("FAIL lsb_bit i=%0d got=%b exp=%b", i, so[1], eb); end
            checks++; if (sv[1] !== ev) begin errs++; $display("FAIL lsb_valid i=%0d got=%b exp=%b", i, sv[1], ev); end
            checks++; if (dn[1] !== (i == 8)) begin errs++; $display("FAIL lsb_done i=%0d got=%b exp=%b", i, dn[1], (i == 8)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic eb, ev;
        stream = 16'b00001111_11110000;
        settle();
        din = 8'h0F;
        din_valid = 1'b1;
        @(negedge clk);
        checks++; if (rd[0] !== 1'b1) begin errs++; $display("FAIL b2b_ready_idle got=%b exp=1", rd[0]); end
        tick();
        din = 8'hF0;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            ev = (j >= 1 && j <= 16);
            eb = ev ? stream[16-j] : 1'b1;
            checks++; if (so[0] !== eb) begin errs++; $display("FAIL b2b_bit j=%0d got=%b exp=%b", j, so[0], eb); end
            checks++; if (sv[0] !== ev) begin errs++; $display("FAIL b2b_valid j=%0d got=%b exp=%b", j, sv[0], ev); end
            checks++; if (dn[0] !== (j == 8 || j == 16)) begin errs++; $display("FAIL b2b_done j=%0d got=%b exp=%b", j, dn[0], (j == 8 || j == 16)); end
            checks++; if (bz[0] !== (j <= 15)) begin errs++; $display("FAIL b2b_busy j=%0d got=%b exp=%b", j, bz[0], (j <= 15)); end
            if (j <= 14) begin
                checks++; if (rd[0] !== (j == 7)) begin errs++; $display("FAIL b2b_ready j=%0d got=%b exp=%b", j, rd[0], (j == 7)); end
            end
            tick();
            if (j == 7) din_valid = 1'b0;
        end
    endtask

    task automatic test_gap();
        logic [7:0] w1, w2;
        logic eb, ev;
        w1 = 8'h3C;
        w2 = 8'hC3;
        settle();
        din = w1;
        din_valid = 1'b1;
        tick();
        din = w2;
        for (int j = 0; j <= 21; j++) begin
            @(negedge clk);
            ev = (j >= 1 && j <= 8) || (j >= 13 && j <= 20);
            eb = (j >= 1 && j <= 8) ? w1[8-j] : ((j >= 13 && j <= 20) ? w2[20-j] : 1'b1);
            checks++; if (so[2] !== eb) begin errs++; $display("FAIL gap_bit j=%0d got=%b exp=%b", j, so[2], eb); end
            checks++; if (sv[2] !== ev) begin errs++; $display("FAIL gap_valid j=%0d got=%b exp=%b", j, sv[2], ev); end
            checks++; if (dn[2] !== (j == 8 || j == 20)) begin errs++; $display("FAIL gap_done j=%0d got=%b exp=%b", j, dn[2], (j == 8 || j == 20)); end
            if (j <= 11) begin
                checks++; if (rd[2] !== (j == 11)) begin errs++; $display("FAIL gap_ready j=%0d got=%b exp=%b", j, rd[2], (j == 11)); end
                checks++; if (bz[2] !== (j <= 10)) begin errs++; $display("FAIL gap_busy j=%0d got=%b exp=%b", j, bz[2], (j <= 10)); end
            end
            tick();
            if (j == 11) din_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] pat;
        settle();
        din = 8'h00;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (4) tick();
        checks++; if ({so[0], sv[0]} !== 2'b01) begin errs++; $display("FAIL mid_bit4 got=%b exp=01", {so[0], sv[0]}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (so[0] !== 1'b1) begin errs++; $display("FAIL mid_async_ser_out got=%b exp=1", so[0]); end
        checks++; if (sv[0] !== 1'b0) begin errs++; $display("FAIL mid_async_valid got=%b exp=0", sv[0]); end
        checks++; if (bz[0] !== 1'b0) begin errs++; $display("FAIL mid_async_busy got=%b exp=0", bz[0]); end
        checks++; if (so[3] !== 1'b0) begin errs++; $display("FAIL mid_async_idle0 got=%b exp=0", so[3]); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (dn[0] !== 1'b0) begin errs++; $display("FAIL mid_no_done k=%0d got=%b exp=0", k, dn[0]); end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (dn[0] !== 1'b0) begin errs++; $display("FAIL mid_no_done_post k=%0d got=%b exp=0", k, dn[0]); end
            tick();
        end
        pat = 8'h81;
        din = pat;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            @(negedge clk);
            checks++; if ({so[0], sv[0], dn[0]} !== {pat[8-i], 1'b1, (i == 8)}) begin
                errs++; $display("FAIL mid_new_word i=%0d got=%b exp=%b", i, {so[0], sv[0], dn[0]}, {pat[8-i], 1'b1, (i == 8)});
            end
        end
    endtask

    // Timing model: an accepted word at edge e owns output cycles e+1..e+W,
    // finishes at e+W, and the block next accepts at e+W (no gap) or e+W+G+1.
    task automatic test_random(input int cfg, input int ncyc);
        bit ev [0:511];
        bit eb [0:511];
        bit ed [0:511];
        int w, g, e, next_ok, last_acc, idx;
        bit msb, ib, x_rd, x_bz;
        w = cW[cfg];
        g = cG[cfg];
        msb = cM[cfg];
        ib = cI[cfg];
        for (int k = 0; k < 512; k++) begin
            ev[k] = 1'b0;
            eb[k] = ib;
            ed[k] = 1'b0;
        end
        next_ok = 0;
        last_acc = -1000;
        settle();
        for (int k = 0; k < ncyc; k++) begin
            din = 8'($urandom);
            din_valid = (k < ncyc - 20) ? ($urandom_range(0, 9) < 6) : 1'b0;
            @(negedge clk);
            x_rd = (k + 1 >= next_ok);
            x_bz = (k >= last_acc) && (k < last_acc + w + g);
            checks++; if (rd[cfg] !== x_rd) begin errs++; $display("FAIL rnd_ready cfg%0d k=%0d got=%b exp=%b", cfg, k, rd[cfg], x_rd); end
            checks++; if (bz[cfg] !== x_bz) begin errs++; $display("FAIL rnd_busy cfg%0d k=%0d got=%b exp=%b", cfg, k, bz[cfg], x_bz); end
            checks++; if (sv[cfg] !== ev[k]) begin errs++; $display("FAIL rnd_valid cfg%0d k=%0d got=%b exp=%b", cfg, k, sv[cfg], ev[k]); end
            checks++; if (so[cfg] !== eb[k]) begin errs++; $display("FAIL rnd_bit cfg%0d k=%0d got=%b exp=%b", cfg, k, so[cfg], eb[k]); end
            checks++; if (dn[cfg] !== ed[k]) begin errs++; $display("FAIL rnd_done cfg%0d k=%0d got=%b exp=%b", cfg, k, dn[cfg], ed[k]); end
            if (din_valid && x_rd) begin
                e = k + 1;
                for (int i = 0; i < w; i++) begin
                    idx = msb ? (w - 1 - i) : i;
                    ev[e+1+i] = 1'b1;
                    eb[e+1+i] = din[idx];
                end
                ed[e+w] = 1'b1;
                last_acc = e;
                next_ok = (g == 0) ? (e + w) : (e + w + g + 1);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_gap();
        test_reset_midword();
        for (int c = 0; c < 4; c++) test_random(c, 200);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
